// File: rtl/uart_gen2_pkg.sv
// Shared types and constants for the second-generation UART receive path.
package uart_gen2_pkg;

  // Receiver frame states; the FSM also drives this onto a debug port.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_t;

  // DATA_BITS encodings.
  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  // FIFO entry layout: {FE, PE, data[7:0]}.
  localparam int ENTRY_W = 10;

  // Oversample positions within a 16-tick bit cell.
  localparam logic [3:0] SAMPLE_A   = 4'd7;
  localparam logic [3:0] SAMPLE_B   = 4'd8;
  localparam logic [3:0] MID_SAMPLE = 4'd9;

  // Index of the last data bit for a DATA_BITS encoding (5..8 bits -> 4..7).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] code);
    return {1'b0, code} + 3'd4;
  endfunction

  // Two-out-of-three vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO holding received entries. Pointers carry an
// extra wrap bit so full and empty are distinguished without a counter.
// A write while full is accepted only when a read happens on the same edge.
module uart_sync_fifo
  import uart_gen2_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = ENTRY_W
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_ok;
  logic         rd_ok;

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == DEPTH_L);
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_en);

  // Head entry is visible combinationally; an empty FIFO reads as zero.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update for accepted writes and reads.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the output.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo_gen2.sv
// UART receiver with 16x oversampling, majority voting, configurable frame
// format, break detection, idle timeout and an integrated receive FIFO.
//
// Read side handshake: RXRDY is the valid indication for the show-ahead head
// entry on RD_DATA/RD_PE/RD_FE. RD_EN acts as ready; an entry is consumed on
// any CLK edge where RD_EN and RXRDY are both high, and RD_EN while RXRDY is
// low has no effect on the FIFO.
module uart_rx_fifo_gen2
  import uart_gen2_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int BAUD_W        = 16,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [BAUD_W-1:0]      BAUD_DIV,
  input  logic [1:0]             DATA_BITS,
  input  logic                   PARITY_EN,
  input  logic                   ODD_N_EVEN,
  input  logic                   TWO_STOP,
  input  logic                   RX,
  input  logic                   RD_EN,
  output logic [7:0]             RD_DATA,
  output logic                   RD_PE,
  output logic                   RD_FE,
  output logic                   RXRDY,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   OVERFLOW,
  input  logic                   CLR_OVERFLOW,
  output logic                   TIMEOUT,
  output logic                   BREAK_DET,
  output rx_state_t              DBG_STATE
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CHARS * 10);

  logic              rx_s1, rx_s2, rx_prev;
  logic [BAUD_W-1:0] tick_cnt;
  logic              tick;
  logic [3:0]        samp_cnt;
  logic              s_a, s_b;
  rx_state_t         state, state_nxt;
  logic [7:0]        data_q;
  logic [2:0]        bit_idx;
  logic              pe_q, fe_q, hi_seen;
  logic              brk_wait;
  logic              push_q, brk_q;
  logic [ENTRY_W-1:0] push_entry;
  logic              ovf_q;
  logic [3:0]        idle_ticks;
  logic [7:0]        idle_bits;

  logic              bit_val, mid, start_edge, do_push;
  logic              fe_final, hi_final;

  logic [ENTRY_W-1:0]     fifo_rd_data;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_level;

  assign tick       = (tick_cnt == '0);
  assign mid        = tick && (state != ST_IDLE) && (samp_cnt == MID_SAMPLE);
  assign bit_val    = maj3(s_a, s_b, rx_s2);
  assign start_edge = (state == ST_IDLE) && rx_prev && !rx_s2 && !brk_wait;
  assign fe_final   = fe_q | ~bit_val;
  assign hi_final   = hi_seen | bit_val;

  // Two-stage synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Free-running oversample tick; BAUD_DIV is only picked up at reload.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)  tick_cnt <= '0;
    else if (tick) tick_cnt <= BAUD_DIV;
    else           tick_cnt <= tick_cnt - 1'b1;
  end

  // Sample position within the current bit cell and the two early votes.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      samp_cnt <= '0;
      s_a      <= 1'b1;
      s_b      <= 1'b1;
    end else if (start_edge) begin
      samp_cnt <= '0;
    end else if (tick && state != ST_IDLE) begin
      samp_cnt <= samp_cnt + 1'b1;
      if (samp_cnt == SAMPLE_A) s_a <= rx_s2;
      if (samp_cnt == SAMPLE_B) s_b <= rx_s2;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; every decision is taken on the mid-bit vote.
  always_comb begin
    state_nxt = state;
    do_push   = 1'b0;
    case (state)
      ST_IDLE:   if (start_edge) state_nxt = ST_START;
      ST_START:  if (mid) state_nxt = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:   if (mid && bit_idx == last_bit_idx(DATA_BITS))
                   state_nxt = PARITY_EN ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (mid) state_nxt = ST_STOP1;
      ST_STOP1:  if (mid) begin
                   if (TWO_STOP) begin
                     state_nxt = ST_STOP2;
                   end else begin
                     state_nxt = ST_IDLE;
                     do_push   = 1'b1;
                   end
                 end
      ST_STOP2:  if (mid) begin
                   state_nxt = ST_IDLE;
                   do_push   = 1'b1;
                 end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Frame datapath: data assembly, parity/framing flags, any-one tracking.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      data_q  <= '0;
      bit_idx <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      hi_seen <= 1'b0;
    end else if (start_edge) begin
      data_q  <= '0;
      bit_idx <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      hi_seen <= 1'b0;
    end else if (mid) begin
      case (state)
        ST_DATA: begin
          data_q[bit_idx] <= bit_val;
          bit_idx         <= bit_idx + 3'd1;
          hi_seen         <= hi_final;
        end
        ST_PARITY: begin
          pe_q    <= (^data_q) ^ bit_val ^ ODD_N_EVEN;
          hi_seen <= hi_final;
        end
        ST_STOP1: begin
          fe_q    <= ~bit_val;
          hi_seen <= hi_final;
        end
        default: ;
      endcase
    end
  end

  // Register the push one cycle after the final stop vote; a frame with no
  // high bit anywhere is a break and also arms the wait-for-idle-line lock.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      push_q     <= 1'b0;
      brk_q      <= 1'b0;
      push_entry <= '0;
      brk_wait   <= 1'b0;
    end else begin
      push_q <= do_push;
      brk_q  <= do_push && !hi_final;
      if (do_push) push_entry <= {fe_final, pe_q, data_q};
      if (do_push && !hi_final) brk_wait <= 1'b1;
      else if (rx_s2)           brk_wait <= 1'b0;
    end
  end

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .wr_en   (push_q),
    .wr_data (push_entry),
    .rd_en   (RD_EN),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Sticky overflow; a drop in the same cycle wins over the clear.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                             ovf_q <= 1'b0;
    else if (push_q && fifo_full && !RD_EN)   ovf_q <= 1'b1;
    else if (CLR_OVERFLOW)                    ovf_q <= 1'b0;
  end

  // Idle timer in bit times while data waits and no frame is in progress.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idle_ticks <= '0;
      idle_bits  <= '0;
    end else if (RD_EN || start_edge || fifo_level == '0) begin
      idle_ticks <= '0;
      idle_bits  <= '0;
    end else if (tick && state == ST_IDLE) begin
      if (idle_ticks == 4'd15) begin
        idle_ticks <= '0;
        if (idle_bits != TO_LIMIT) idle_bits <= idle_bits + 8'd1;
      end else begin
        idle_ticks <= idle_ticks + 4'd1;
      end
    end
  end

  assign {RD_FE, RD_PE, RD_DATA} = fifo_rd_data;
  assign RXRDY     = !fifo_empty;
  assign LEVEL     = fifo_level;
  assign OVERFLOW  = ovf_q;
  assign TIMEOUT   = (idle_bits == TO_LIMIT);
  assign BREAK_DET = brk_q;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_uart_rx_fifo_gen2.sv
// Self-checking bench for uart_rx_fifo_gen2 with a frame-level reference model.
module tb_uart_rx_fifo_gen2;
  import uart_gen2_pkg::*;

  localparam int DEPTH = 4;
  localparam int BAUD_W = 16;
  localparam int TIMEOUT_CHARS = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic [BAUD_W-1:0] BAUD_DIV = 16'd3;
  logic [1:0]        DATA_BITS = DBITS_8;
  logic              PARITY_EN = 1'b0;
  logic              ODD_N_EVEN = 1'b0;
  logic              TWO_STOP = 1'b0;
  logic              RX = 1'b1;
  logic              RD_EN = 1'b0;
  logic              CLR_OVERFLOW = 1'b0;
  logic [7:0]        RD_DATA;
  logic              RD_PE, RD_FE, RXRDY, OVERFLOW, TIMEOUT, BREAK_DET;
  logic [LW-1:0]     LEVEL;
  rx_state_t         DBG_STATE;

  int n_cmp = 0;
  int n_fail = 0;
  int brk_cnt = 0;
  logic [9:0] exp_q[$];

  uart_rx_fifo_gen2 #(.DEPTH(DEPTH), .BAUD_W(BAUD_W), .TIMEOUT_CHARS(TIMEOUT_CHARS)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .BAUD_DIV(BAUD_DIV), .DATA_BITS(DATA_BITS),
    .PARITY_EN(PARITY_EN), .ODD_N_EVEN(ODD_N_EVEN), .TWO_STOP(TWO_STOP), .RX(RX),
    .RD_EN(RD_EN), .RD_DATA(RD_DATA), .RD_PE(RD_PE), .RD_FE(RD_FE), .RXRDY(RXRDY),
    .LEVEL(LEVEL), .OVERFLOW(OVERFLOW), .CLR_OVERFLOW(CLR_OVERFLOW), .TIMEOUT(TIMEOUT),
    .BREAK_DET(BREAK_DET), .DBG_STATE(DBG_STATE)
  );

  // Clock and break-pulse monitor
  always #5 CLK = ~CLK;
  always @(negedge CLK) if (BREAK_DET === 1'b1) brk_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic int bit_clks();
    return 16 * (int'(BAUD_DIV) + 1);
  endfunction

  function automatic int nbits();
    return int'(DATA_BITS) + 5;
  endfunction

  // Reference model: parity bit that makes the frame correct.
  function automatic logic good_par(input logic [7:0] d, input int nb, input logic odd);
    logic [7:0] m;
    m = 8'((1 << nb) - 1);
    return logic'($countones(d & m) % 2) ^ odd;
  endfunction

  // Reference model: the FIFO entry a frame should produce.
  function automatic logic [9:0] model_entry(input logic [7:0] d, input int nb, input logic pen,
                                             input logic odd, input logic pbit, input logic s1,
                                             input logic s2, input logic two);
    logic [7:0] m, dm;
    int ones;
    logic pe, fe;
    m = 8'((1 << nb) - 1);
    dm = d & m;
    ones = $countones(dm) + int'(pbit);
    pe = pen && ((ones % 2) != (odd ? 1 : 0));
    fe = !s1 || (two && !s2);
    return {fe, pe, dm};
  endfunction

  // Driver: one serial bit cell
  task automatic drive_bit(input logic v);
    RX = v;
    cyc(bit_clks());
  endtask

  // Driver: full frame using the current format inputs, then gap idle bits
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1,
                            input logic s2, input int gap);
    drive_bit(1'b0);
    for (int i = 0; i < nbits(); i++) drive_bit(d[i]);
    if (PARITY_EN) drive_bit(pbit);
    drive_bit(s1);
    if (TWO_STOP) drive_bit(s2);
    for (int i = 0; i < gap; i++) drive_bit(1'b1);
  endtask

  // Scoreboard: check level, then pop and compare every expected entry
  task automatic drain(input string tag);
    logic [9:0] got, want;
    n_cmp++;
    if (LEVEL !== LW'(exp_q.size())) begin
      n_fail++;
      $display("FAIL %s_level: got %0d want %0d", tag, LEVEL, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got = {RD_FE, RD_PE, RD_DATA};
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s_entry: got fe=%b pe=%b d=%h want fe=%b pe=%b d=%h",
                 tag, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
      end
      RD_EN = 1'b1;
      cyc(1);
      RD_EN = 1'b0;
    end
    n_cmp++;
    if (RXRDY !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_empty: rxrdy got %b want 0", tag, RXRDY);
    end
  endtask

  // Wait (bounded) for the FSM to pass STOP1 and return to IDLE
  task automatic wait_stop_sample(input string tag);
    for (int i = 0; i < 20000 && DBG_STATE != ST_STOP1; i++) cyc(1);
    for (int i = 0; i < 20000 && DBG_STATE == ST_STOP1; i++) cyc(1);
    n_cmp++;
    if (DBG_STATE !== ST_IDLE) begin
      n_fail++;
      $display("FAIL %s_stop_sample: state got %0d want %0d", tag, DBG_STATE, ST_IDLE);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    cyc(3);
    n_cmp++;
    if ({RD_DATA, RD_PE, RD_FE, RXRDY, LEVEL, OVERFLOW, TIMEOUT, BREAK_DET} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got d=%h pe=%b fe=%b rdy=%b lvl=%0d ovf=%b to=%b brk=%b want all 0",
               RD_DATA, RD_PE, RD_FE, RXRDY, LEVEL, OVERFLOW, TIMEOUT, BREAK_DET);
    end
    n_cmp++;
    if (DBG_STATE !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want %0d", DBG_STATE, ST_IDLE);
    end
    RESET_N = 1'b1;
    cyc(5);
  endtask

  task automatic test_8n1();
    BAUD_DIV = 16'd3; DATA_BITS = DBITS_8; PARITY_EN = 1'b0; TWO_STOP = 1'b0;
    exp_q.push_back(model_entry(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    fork
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1);
      begin
        wait_stop_sample("8n1");
        n_cmp++;
        if (RXRDY !== 1'b0) begin
          n_fail++;
          $display("FAIL 8n1_rxrdy_at_sample: got %b want 0", RXRDY);
        end
        cyc(1);
        n_cmp++;
        if (RXRDY !== 1'b1 || LEVEL !== LW'(1)) begin
          n_fail++;
          $display("FAIL 8n1_rxrdy_after: got rdy=%b lvl=%0d want rdy=1 lvl=1", RXRDY, LEVEL);
        end
      end
    join
    drain("8n1");
  endtask

  task automatic test_7o2();
    logic p;
    BAUD_DIV = 16'd3; DATA_BITS = DBITS_7; PARITY_EN = 1'b1; ODD_N_EVEN = 1'b1; TWO_STOP = 1'b1;
    p = ~good_par(8'h55, 7, 1'b1);
    exp_q.push_back(model_entry(8'h55, 7, 1'b1, 1'b1, p, 1'b1, 1'b1, 1'b1));
    send_frame(8'h55, p, 1'b1, 1'b1, 1);
    p = good_par(8'h55, 7, 1'b1);
    exp_q.push_back(model_entry(8'h55, 7, 1'b1, 1'b1, p, 1'b1, 1'b0, 1'b1));
    send_frame(8'h55, p, 1'b1, 1'b0, 1);
    drain("7o2");
  endtask

  task automatic test_glitch();
    BAUD_DIV = 16'd3; DATA_BITS = DBITS_8; PARITY_EN = 1'b0; TWO_STOP = 1'b0;
    RX = 1'b0;
    cyc(20);
    RX = 1'b1;
    cyc(128);
    n_cmp++;
    if (LEVEL !== '0 || RXRDY !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_level: got lvl=%0d rdy=%b want 0/0", LEVEL, RXRDY);
    end
    n_cmp++;
    if (DBG_STATE !== ST_IDLE) begin
      n_fail++;
      $display("FAIL glitch_state: got %0d want %0d", DBG_STATE, ST_IDLE);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic [9:0] got, want;
    BAUD_DIV = 16'd1; DATA_BITS = DBITS_8; PARITY_EN = 1'b0; TWO_STOP = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = 8'($urandom_range(0, 255)) | 8'h01;
      if (i < DEPTH) exp_q.push_back(model_entry(d, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      send_frame(d, 1'b0, 1'b1, 1'b1, 0);
    end
    cyc(4);
    n_cmp++;
    if (LEVEL !== LW'(DEPTH) || OVERFLOW !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_full: got lvl=%0d ovf=%b want lvl=%0d ovf=1", LEVEL, OVERFLOW, DEPTH);
    end
    CLR_OVERFLOW = 1'b1;
    cyc(1);
    CLR_OVERFLOW = 1'b0;
    n_cmp++;
    if (OVERFLOW !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b want 0", OVERFLOW);
    end
    d = 8'h3C;
    fork
      send_frame(d, 1'b0, 1'b1, 1'b1, 1);
      begin
        wait_stop_sample("ovf_pop");
        want = exp_q.pop_front();
        got = {RD_FE, RD_PE, RD_DATA};
        n_cmp++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL ovf_pop_head: got %h want %h", got, want);
        end
        RD_EN = 1'b1;
        cyc(1);
        RD_EN = 1'b0;
      end
    join
    exp_q.push_back(model_entry(d, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    n_cmp++;
    if (LEVEL !== LW'(DEPTH) || OVERFLOW !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_simul: got lvl=%0d ovf=%b want lvl=%0d ovf=0", LEVEL, OVERFLOW, DEPTH);
    end
    drain("ovf");
  endtask

  task automatic test_break();
    BAUD_DIV = 16'd1; DATA_BITS = DBITS_8; PARITY_EN = 1'b0; TWO_STOP = 1'b0;
    brk_cnt = 0;
    RX = 1'b0;
    cyc(20 * bit_clks());
    n_cmp++;
    if (LEVEL !== LW'(1) || brk_cnt !== 1) begin
      n_fail++;
      $display("FAIL break_low: got lvl=%0d pulses=%0d want 1/1", LEVEL, brk_cnt);
    end
    RX = 1'b1;
    cyc(3 * bit_clks());
    n_cmp++;
    if (LEVEL !== LW'(1) || brk_cnt !== 1) begin
      n_fail++;
      $display("FAIL break_release: got lvl=%0d pulses=%0d want 1/1", LEVEL, brk_cnt);
    end
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    exp_q.push_back(model_entry(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1);
    drain("break");
  endtask

  task automatic test_random();
    logic [7:0] d, m;
    logic p, s1, s2;
    int k;
    for (int g = 0; g < 5; g++) begin
      BAUD_DIV = 16'($urandom_range(1, 3));
      DATA_BITS = 2'($urandom_range(0, 3));
      PARITY_EN = 1'($urandom_range(0, 1));
      ODD_N_EVEN = 1'($urandom_range(0, 1));
      TWO_STOP = 1'($urandom_range(0, 1));
      RX = 1'b1;
      cyc(2 * bit_clks());
      k = $urandom_range(1, DEPTH);
      for (int j = 0; j < k; j++) begin
        d = 8'($urandom_range(0, 255));
        m = 8'((1 << nbits()) - 1);
        p = good_par(d, nbits(), ODD_N_EVEN) ^ ($urandom_range(0, 3) == 0);
        s1 = ($urandom_range(0, 4) != 0);
        s2 = ($urandom_range(0, 4) != 0);
        if ((d & m) == 8'h00) begin
          s1 = 1'b1;
          s2 = 1'b1;
        end
        exp_q.push_back(model_entry(d, nbits(), PARITY_EN, ODD_N_EVEN, p, s1, s2, TWO_STOP));
        send_frame(d, p, s1, s2, ((TWO_STOP ? s2 : s1) == 1'b0) ? 1 : int'($urandom_range(0, 1)));
      end
      cyc(bit_clks());
      drain("random");
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [9:0] want, got;
    BAUD_DIV = 16'd3; DATA_BITS = DBITS_8; PARITY_EN = 1'b0; TWO_STOP = 1'b0;
    RX = 1'b1;
    cyc(2 * bit_clks());
    want = model_entry(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n = 0;
    fork
      send_frame(8'h96, 1'b0, 1'b1, 1'b1, 0);
      begin
        for (int i = 0; i < 20000 && RXRDY !== 1'b1; i++) cyc(1);
        while (TIMEOUT !== 1'b1 && n < 3000) begin
          cyc(1);
          n++;
        end
      end
    join
    n_cmp++;
    if (n < 639 * 4 + 1 || n > 640 * 4) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles want %0d..%0d", n, 639 * 4 + 1, 640 * 4);
    end
    got = {RD_FE, RD_PE, RD_DATA};
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL timeout_entry: got %h want %h", got, want);
    end
    RD_EN = 1'b1;
    cyc(1);
    RD_EN = 1'b0;
    n_cmp++;
    if (TIMEOUT !== 1'b0 || LEVEL !== '0) begin
      n_fail++;
      $display("FAIL timeout_clear: got to=%b lvl=%0d want 0/0", TIMEOUT, LEVEL);
    end
  endtask

  task automatic test_reset_mid_frame();
    BAUD_DIV = 16'd1; DATA_BITS = DBITS_8; PARITY_EN = 1'b0; TWO_STOP = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    RESET_N = 1'b0;
    cyc(2);
    n_cmp++;
    if ({RD_DATA, RD_PE, RD_FE, RXRDY, LEVEL, OVERFLOW, TIMEOUT, BREAK_DET} !== '0 ||
        DBG_STATE !== ST_IDLE) begin
      n_fail++;
      $display("FAIL midreset_outputs: got d=%h rdy=%b lvl=%0d state=%0d want all 0",
               RD_DATA, RXRDY, LEVEL, DBG_STATE);
    end
    RX = 1'b1;
    RESET_N = 1'b1;
    cyc(2 * bit_clks());
    exp_q.delete();
    exp_q.push_back(model_entry(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1);
    drain("midreset");
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_8n1();
    test_7o2();
    test_glitch();
    test_overflow();
    test_break();
    test_random();
    test_timeout();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
